tone_write_scheduler: RTL and testbench

- Front end for the 4-channel tone generator datapath.
- Owns the free-running 10-bit master frame counter that sequences the datapath.
- Accepts host register writes (valid/ready) into a small FIFO.
- Forwards each write as a single-cycle register-write pulse, only inside the safe window of the frame. No channel parameter ever changes between phase update, waveform sampling and mixing of the same frame.

---
 rtl/tone_gen_pkg.sv | 26 ++
 rtl/cmd_fifo.sv | 73 +++++++
 rtl/tone_write_scheduler.sv | 91 +++++++++
 tb/tb_tone_write_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_gen_pkg.sv
// Shared constants and types for the 4-channel tone generator: datapath widths,
// register address groups and the default start of the safe write window.
package tone_gen_pkg;

    localparam int MASTER_COUNT_W    = 10;
    localparam int DATA_W            = 16;
    localparam int ADDR_W            = 4;

    // Phases 0..2 of the datapath occupy master counts 0..11, so writes start at 12.
    localparam int WIN_START_DEFAULT = 12;

    localparam logic [1:0] ADDR_GRP_INCR = 2'd0;
    localparam logic [1:0] ADDR_GRP_VOL  = 2'd1;
    localparam logic [1:0] ADDR_GRP_WAVE = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } reg_write_t;

    function automatic logic in_issue_window(input logic [MASTER_COUNT_W-1:0] count,
                                             input int win_start);
        return int'(count) >= win_start;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with registered occupancy and a combinational head.
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                     clk_in,
    input  logic                     reset_n_in,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_FULL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      level_d = level_q + LVL_ONE;
            else if (do_pop && !do_push) level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; the pointers and level alone define valid entries.
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/tone_write_scheduler.sv
// Front end of the tone generator: free-running frame counter plus a write queue
// that forwards host writes only inside the safe window of each frame.
module tone_write_scheduler
    import tone_gen_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WIN_START  = WIN_START_DEFAULT
) (
    input  logic                        clk_in,
    input  logic                        reset_n_in,
    input  logic [DATA_W-1:0]           host_data_in,
    input  logic [ADDR_W-1:0]           host_addr_in,
    input  logic                        host_valid_in,
    output logic                        host_ready_out,
    input  logic                        clear_in,
    output logic [MASTER_COUNT_W-1:0]   master_count_out,
    output logic                        frame_start_out,
    output logic [DATA_W-1:0]           data_out,
    output logic [ADDR_W-1:0]           addr_out,
    output logic                        data_valid_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_out
);

    localparam logic [MASTER_COUNT_W-1:0] CNT_ONE = MASTER_COUNT_W'(1);

    logic [MASTER_COUNT_W-1:0] count_q, count_d;
    logic [DATA_W-1:0]         data_q, data_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic                      valid_q, valid_d;

    reg_write_t push_cmd, head_cmd;
    logic       fifo_full, fifo_empty, pop;

    assign push_cmd.addr = host_addr_in;
    assign push_cmd.data = host_data_in;

    assign host_ready_out = !fifo_full && !clear_in;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_cmd_fifo (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .push_i     (host_valid_in && host_ready_out),
        .pop_i      (pop),
        .clear_i    (clear_in),
        .wdata_i    (push_cmd),
        .rdata_o    (head_cmd),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level_out)
    );

    assign count_d = count_q + CNT_ONE;

    // The decision looks at the count the strobe will be seen with, so a wrap to 0 never pops.
    assign pop = !fifo_empty && !clear_in && in_issue_window(count_d, WIN_START);

    always_comb begin
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        if (pop) begin
            data_d  = head_cmd.data;
            addr_d  = head_cmd.addr;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            count_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign master_count_out = count_q;
    assign frame_start_out  = (count_q == '0);
    assign data_out         = data_q;
    assign addr_out         = addr_q;
    assign data_valid_out   = valid_q;

endmodule

// File: tb/tb_tone_write_scheduler.sv
// Scoreboard bench for tone_write_scheduler: directed frame scenarios followed by
// randomized host traffic with occasional clears, checked against a timing model.
module tb_tone_write_scheduler;

    localparam int FIFO_DEPTH = 4;
    localparam int WIN_START  = 12;
    localparam int FRAME      = 1024;

    logic        clk_in = 1'b0;
    logic        reset_n_in = 1'b0;
    logic [15:0] host_data_in = '0;
    logic [3:0]  host_addr_in = '0;
    logic        host_valid_in = 1'b0;
    logic        host_ready_out;
    logic        clear_in = 1'b0;
    logic [9:0]  master_count_out;
    logic        frame_start_out;
    logic [15:0] data_out;
    logic [3:0]  addr_out;
    logic        data_valid_out;
    logic [2:0]  fifo_level_out;

    tone_write_scheduler #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIN_START  (WIN_START)
    ) dut (
        .clk_in           (clk_in),
        .reset_n_in       (reset_n_in),
        .host_data_in     (host_data_in),
        .host_addr_in     (host_addr_in),
        .host_valid_in    (host_valid_in),
        .host_ready_out   (host_ready_out),
        .clear_in         (clear_in),
        .master_count_out (master_count_out),
        .frame_start_out  (frame_start_out),
        .data_out         (data_out),
        .addr_out         (addr_out),
        .data_valid_out   (data_valid_out),
        .fifo_level_out   (fifo_level_out)
    );

    always #5 clk_in = ~clk_in;

    // Expected write: accepted in absolute cycle acc, strobe expected in absolute cycle exp.
    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        longint      acc;
        longint      exp;
    } exp_t;

    exp_t   sb[$];
    longint abs_cnt;
    longint last_strobe = -100;
    int     n_checks = 0;
    int     n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Absolute cycle count since the last reset release.
    always @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) abs_cnt <= 0;
        else             abs_cnt <= abs_cnt + 1;
    end

    // Acceptor: records handshakes and predicts their strobe cycle.
    always @(negedge clk_in) begin
        exp_t e;
        #1;
        if (!reset_n_in) begin
            sb.delete();
            last_strobe = -100;
        end else if (clear_in) begin
            while (sb.size() > 0 && sb[$].exp > abs_cnt) void'(sb.pop_back());
            last_strobe = abs_cnt;
        end else if (host_valid_in && host_ready_out) begin
            e.addr = host_addr_in;
            e.data = host_data_in;
            e.acc  = abs_cnt;
            e.exp  = (abs_cnt + 2 > last_strobe + 1) ? abs_cnt + 2 : last_strobe + 1;
            if (e.exp % FRAME < WIN_START) e.exp = e.exp - (e.exp % FRAME) + WIN_START;
            last_strobe = e.exp;
            sb.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    always @(negedge clk_in) begin
        exp_t   e;
        longint lvl;
        if (!reset_n_in) begin
            check("reset_count", master_count_out, 0);
            check("reset_frame_start", frame_start_out, 1);
            check("reset_valid", data_valid_out, 0);
            check("reset_data", data_out, 0);
            check("reset_addr", addr_out, 0);
            check("reset_level", fifo_level_out, 0);
        end else begin
            check("master_count", master_count_out, abs_cnt % FRAME);
            check("frame_start", frame_start_out, (abs_cnt % FRAME) == 0);
            lvl = 0;
            foreach (sb[i]) if (sb[i].acc < abs_cnt && abs_cnt < sb[i].exp) lvl++;
            check("fifo_level", fifo_level_out, lvl);
            check("host_ready", host_ready_out, (lvl < FIFO_DEPTH) && !clear_in);
            if (data_valid_out) begin
                check("strobe_in_window", master_count_out >= WIN_START, 1);
                if (sb.size() == 0) begin
                    check("spurious_strobe", data_valid_out, 0);
                end else begin
                    e = sb.pop_front();
                    check("strobe_cycle", abs_cnt, e.exp);
                    check("strobe_addr", addr_out, e.addr);
                    check("strobe_data", data_out, e.data);
                end
            end else if (sb.size() > 0 && sb[0].exp <= abs_cnt) begin
                check("missed_strobe", data_valid_out, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic goto_count(input int c);
        for (int i = 0; i < 2100; i++) begin
            if (abs_cnt % FRAME == c) return;
            tick();
        end
        check("goto_timeout", abs_cnt % FRAME, c);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [15:0] d);
        logic ok;
        host_valid_in = 1'b1;
        host_addr_in  = a;
        host_data_in  = d;
        for (int i = 0; i < 3000; i++) begin
            ok = host_ready_out;
            tick();
            if (ok) begin
                host_valid_in = 1'b0;
                return;
            end
        end
        host_valid_in = 1'b0;
        check("write_timeout", 0, 1);
    endtask

    initial begin
        repeat (5) tick();
        reset_n_in = 1'b1;

        // Single writes inside and before the window.
        goto_count(20);
        host_write(4'h0, 16'h1234);
        goto_count(5);
        host_write(4'h5, 16'hBEEF);

        // Back-to-back burst mid-frame.
        goto_count(100);
        for (int i = 0; i < 4; i++) host_write(4'(i + 8), 16'(16'hA000 + i));

        // Overfill from frame start.
        goto_count(0);
        for (int i = 0; i < 5; i++) host_write(4'(i), 16'(16'hC000 + i));

        // Writes near the frame wrap.
        goto_count(1020);
        host_write(4'h1, 16'h1020);
        goto_count(1022);
        host_write(4'h2, 16'h1022);

        // Clear with queued writes before the window.
        goto_count(2);
        for (int i = 0; i < 3; i++) host_write(4'h3, 16'(16'hD000 + i));
        goto_count(5);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;

        // Reset with one write in flight.
        goto_count(499);
        host_write(4'h6, 16'h0499);
        reset_n_in = 1'b0;
        repeat (3) tick();
        reset_n_in = 1'b1;

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 2500; i++) begin
            host_valid_in = 1'($urandom_range(0, 1));
            host_addr_in  = 4'($urandom_range(0, 15));
            host_data_in  = 16'($urandom);
            clear_in      = ($urandom_range(0, 49) == 0);
            tick();
        end
        host_valid_in = 1'b0;
        clear_in      = 1'b0;
        repeat (1100) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
